// File: rtl/sound_env_gen.sv
// Synchronous volume envelope for square/noise channels.
// Steps target_vol once every N env_ticks until it saturates.
module sound_env_gen #(
  parameter int VOL_W = 4,
  parameter int PER_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             env_tick,
  input  logic             trigger,
  input  logic [VOL_W-1:0] initial_volume,
  input  logic             envelope_increasing,
  input  logic [PER_W-1:0] num_envelope_sweeps,
  output logic [VOL_W-1:0] target_vol,
  output logic             env_active,
  output logic             dac_en
);

  localparam logic [VOL_W-1:0] VMAX = '1;
  localparam logic [VOL_W-1:0] VZERO = '0;
  localparam logic [PER_W-1:0] PONE = 1;
  localparam logic [PER_W-1:0] PZERO = '0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [PER_W-1:0] timer;
  logic [VOL_W-1:0] step_vol;
  logic             init_lim;
  logic             cur_lim;
  logic             step_lim;
  logic             run_next;

  always_comb begin
    init_lim = envelope_increasing ? (initial_volume == VMAX)
                                   : (initial_volume == VZERO);
    cur_lim  = envelope_increasing ? (target_vol == VMAX)
                                   : (target_vol == VZERO);
    step_vol = envelope_increasing ? target_vol + 1'b1
                                   : target_vol - 1'b1;
    step_lim = envelope_increasing ? (step_vol == VMAX)
                                   : (step_vol == VZERO);
    run_next = (num_envelope_sweeps != PZERO) && !init_lim;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= PZERO;
      target_vol <= VZERO;
      env_active <= 1'b0;
      dac_en     <= 1'b0;
    end else begin
      dac_en <= (initial_volume != VZERO) | envelope_increasing;
      // trigger takes priority; a coincident tick is dropped
      if (trigger) begin
        target_vol <= initial_volume;
        timer      <= num_envelope_sweeps;
        state      <= run_next ? RUN : DONE;
        env_active <= run_next;
      end else if (state == RUN && env_tick) begin
        if (timer > PONE) begin
          timer <= timer - PONE;
        end else if (num_envelope_sweeps == PZERO || cur_lim) begin
          state      <= DONE;
          env_active <= 1'b0;
        end else begin
          timer      <= num_envelope_sweeps;
          target_vol <= step_vol;
          if (step_lim) begin
            state      <= DONE;
            env_active <= 1'b0;
          end
        end
      end
    end
  end

endmodule
